// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, state type and address helper for the conv2 kernel fetcher
package conv_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int KLEN = 25;
  localparam int NUM_K = 10;
  localparam int NPAIR = (KLEN + 1) / 2;
  localparam int PAIR_W = $clog2(NPAIR + 1);
  localparam int FIFO_W = 2 * DATA_W + 2;
  localparam bit KLEN_ODD = (KLEN % 2) == 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  typedef logic [ADDR_W-1:0] addr_t;
  function automatic addr_t even_addr(addr_t base, logic [PAIR_W-1:0] pair);
    return base + addr_t'({pair, 1'b0});
  endfunction
endpackage

// File: rtl/conv2_kernel_fetch_if.sv
// conv2_kernel_fetch_if: ROM read port plus weight-pair stream between fetcher and MAC array
interface conv2_kernel_fetch_if;
  import conv_pkg::*;
  logic [ADDR_W-1:0] rom_address_a, rom_address_b;
  logic [DATA_W-1:0] rom_q_a, rom_q_b, out_w0, out_w1;
  logic out_valid, out_ready, out_w1_valid, out_last;
  modport master(
    output rom_address_a, rom_address_b, out_valid, out_w0, out_w1, out_w1_valid, out_last,
    input rom_q_a, rom_q_b, out_ready
  );
  modport slave(
    input rom_address_a, rom_address_b, out_valid, out_w0, out_w1, out_w1_valid, out_last,
    output rom_q_a, rom_q_b, out_ready
  );
endinterface

// File: rtl/conv_weight_skid_fifo.sv
// conv_weight_skid_fifo: 2-entry buffer for returned weight pairs {w0, w1, w1_valid, last}
module conv_weight_skid_fifo
  import conv_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic              ready,
  input  logic [FIFO_W-1:0] din,
  output logic              valid,
  output logic [1:0]        count,
  output logic [FIFO_W-1:0] dout
);
  logic [FIFO_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic pop;
  always_comb begin
    pop = (cnt_q != 2'd0) && ready;
    head_d = (push && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1))) ? din :
             (pop && cnt_q == 2'd2) ? tail_q : head_q;
    tail_d = (push && (cnt_q == 2'd2 ? pop : (cnt_q == 2'd1 && !pop))) ? din : tail_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
    end
  end
  assign valid = cnt_q != 2'd0;
  assign count = cnt_q;
  assign dout = head_q;
endmodule

// File: rtl/conv2_kernel_fetch.sv
// conv2_kernel_fetch: walks one kernel of the dual-port weight ROM, streaming even/odd pairs
module conv2_kernel_fetch
  import conv_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] kernel_sel,
  output logic       busy,
  output logic       done,
  output logic       err,
  conv2_kernel_fetch_if.master bus
);
  state_t state_q, state_d;
  addr_t base_q, base_d, addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic addr_ok_q, addr_ok_d, inf_q, inf_d, inf_last_q, inf_last_d, inf_w1v_q, inf_w1v_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic bad_sel, accept, pop, issue, last_issue, load_addr, fifo_valid;
  logic [1:0] count;
  logic [2:0] level;
  logic [FIFO_W-1:0] din, dout;
  always_comb begin
    bad_sel = kernel_sel >= 4'(NUM_K);
    accept = state_q == IDLE && start && !bad_sel;
    pop = fifo_valid && bus.out_ready;
    // occupancy once the in-flight pair lands and this cycle's pop leaves
    level = 3'(count) + 3'(inf_q) - 3'(pop);
    issue = state_q == FETCH && addr_ok_q && level < 3'd2;
    last_issue = issue && pair_q == PAIR_W'(NPAIR - 1);
    pair_d = accept ? '0 : pair_q + PAIR_W'(issue);
    base_d = accept ? addr_t'(kernel_sel) * addr_t'(KLEN) : base_q;
    // addresses lead the counter so they never step past the kernel's last weight
    load_addr = state_q == FETCH && (!addr_ok_q || (issue && !last_issue));
    addr_a_d = load_addr ? even_addr(base_q, pair_d) : addr_a_q;
    addr_b_d = !load_addr ? addr_b_q :
               (KLEN_ODD && pair_d == PAIR_W'(NPAIR - 1)) ? addr_a_d : addr_a_d + addr_t'(1);
    addr_ok_d = state_q == FETCH;
    inf_d = issue;
    inf_last_d = last_issue;
    inf_w1v_d = !(KLEN_ODD && last_issue);
    state_d = state_q == IDLE ? (accept ? FETCH : IDLE) :
              state_q == FETCH ? (last_issue ? DRAIN : FETCH) :
              (pop && dout[0]) ? IDLE : DRAIN;
    done_d = state_q == DRAIN && pop && dout[0];
    busy_d = state_d != IDLE;
    err_d = state_q == IDLE && start && bad_sel;
    din = {bus.rom_q_a, inf_w1v_q ? bus.rom_q_b : {DATA_W{1'b0}}, inf_w1v_q, inf_last_q};
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      base_q <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      pair_q <= '0;
      addr_ok_q <= 1'b0;
      inf_q <= 1'b0;
      inf_last_q <= 1'b0;
      inf_w1v_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      pair_q <= pair_d;
      addr_ok_q <= addr_ok_d;
      inf_q <= inf_d;
      inf_last_q <= inf_last_d;
      inf_w1v_q <= inf_w1v_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  conv_weight_skid_fifo u_fifo (
    .clock(clock), .reset_n(reset_n), .push(inf_q), .ready(bus.out_ready), .din(din),
    .valid(fifo_valid), .count(count), .dout(dout)
  );
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign bus.rom_address_a = addr_a_q;
  assign bus.rom_address_b = addr_b_q;
  assign bus.out_valid = fifo_valid;
  assign {bus.out_w0, bus.out_w1, bus.out_w1_valid, bus.out_last} = dout;
endmodule

// File: tb/tb_conv2_kernel_fetch.sv
// tb_conv2_kernel_fetch: randomized self-checking bench with ROM model and pair-stream reference
module tb_conv2_kernel_fetch;
  localparam int KL = 25;
  localparam int NP = (KL + 1) / 2;
  logic clk = 0, rst_n = 0, start = 0;
  logic [3:0] sel = 0;
  logic busy, done, err;
  logic [15:0] rom [256];
  int checks = 0, failures = 0;
  logic [33:0] got [$];
  int stab_viol = 0, err_cnt = 0;
  logic [7:0] max_addr = 0;
  logic stalled = 0;
  logic [33:0] held, cur;

  conv2_kernel_fetch_if bus();
  conv2_kernel_fetch dut (
    .clock(clk), .reset_n(rst_n), .start(start), .kernel_sel(sel),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    bus.rom_q_a <= rom[bus.rom_address_a];
    bus.rom_q_b <= rom[bus.rom_address_b];
  end
  assign cur = {bus.out_w0, bus.out_w1, bus.out_w1_valid, bus.out_last};

  always @(negedge clk) begin
    if (!rst_n) stalled = 0;
    else begin
      if (stalled && (!bus.out_valid || cur !== held)) stab_viol++;
      if (bus.out_valid && bus.out_ready) got.push_back(cur);
      stalled = bus.out_valid && !bus.out_ready;
      held = cur;
      if (bus.rom_address_a > max_addr) max_addr = bus.rom_address_a;
      if (bus.rom_address_b > max_addr) max_addr = bus.rom_address_b;
      if (err) err_cnt++;
    end
  end

  function automatic logic [33:0] exp_pair(int k, int p);
    int i;
    logic v;
    logic [15:0] w0, w1;
    i = k * KL + 2 * p;
    v = (2 * p + 1) < KL;
    w0 = 16'(32'h1000 + i);
    w1 = v ? 16'(32'h1000 + i + 1) : 16'h0000;
    return {w0, w1, v, 1'(p == NP - 1)};
  endfunction

  task automatic start_kernel(input int k);
    @(posedge clk); #1;
    start = 1;
    sel = 4'(k);
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic drain(input int mode, output int cyc);
    cyc = 0;
    while (cyc < 300) begin
      bus.out_ready = mode == 0 ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
      if (done) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, bus.out_valid} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, err, bus.out_valid});
    end
    checks++;
    if ({bus.rom_address_a, bus.rom_address_b} !== 16'h0) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=0000", {bus.rom_address_a, bus.rom_address_b});
    end
    checks++;
    if ({bus.out_w0, bus.out_w1} !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=00000000", {bus.out_w0, bus.out_w1});
    end
    rst_n = 1;
  endtask

  task automatic test_sel0;
    int c, cyc;
    got.delete();
    bus.out_ready = 1;
    start_kernel(0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL sel0_busy got=%b exp=1", busy);
    end
    c = 0;
    while (!bus.out_valid && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (c !== 3) begin
      failures++;
      $display("FAIL sel0_latency got=%0d exp=3", c);
    end
    drain(0, cyc);
    checks++;
    if (done !== 1'b1 || cyc !== NP) begin
      failures++;
      $display("FAIL sel0_done got=%b/%0d exp=1/%0d", done, cyc, NP);
    end
    checks++;
    if (got.size() !== NP) begin
      failures++;
      $display("FAIL sel0_count got=%0d exp=%0d", got.size(), NP);
    end
    for (int p = 0; p < NP && p < got.size(); p++) begin
      checks++;
      if (got[p] !== exp_pair(0, p)) begin
        failures++;
        $display("FAIL sel0_pair%0d got=%h exp=%h", p, got[p], exp_pair(0, p));
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL sel0_pulse got=%b exp=00", {done, busy});
    end
  endtask

  task automatic test_random9;
    int cyc;
    got.delete();
    stab_viol = 0;
    max_addr = 0;
    bus.out_ready = 1'($urandom_range(0, 1));
    start_kernel(9);
    drain(1, cyc);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL sel9_done got=%b exp=1 after %0d cycles", done, cyc);
    end
    checks++;
    if (got.size() !== NP) begin
      failures++;
      $display("FAIL sel9_count got=%0d exp=%0d", got.size(), NP);
    end
    for (int p = 0; p < NP && p < got.size(); p++) begin
      checks++;
      if (got[p] !== exp_pair(9, p)) begin
        failures++;
        $display("FAIL sel9_pair%0d got=%h exp=%h", p, got[p], exp_pair(9, p));
      end
    end
    checks++;
    if (stab_viol !== 0) begin
      failures++;
      $display("FAIL sel9_stable got=%0d exp=0", stab_viol);
    end
    checks++;
    if (max_addr !== 8'hF9) begin
      failures++;
      $display("FAIL sel9_maxaddr got=%h exp=f9", max_addr);
    end
  endtask

  task automatic test_err;
    logic [15:0] a0;
    int e0;
    a0 = {bus.rom_address_a, bus.rom_address_b};
    e0 = err_cnt;
    start_kernel($urandom_range(10, 15));
    checks++;
    if ({err, busy} !== 2'b10) begin
      failures++;
      $display("FAIL err_pulse got=%b exp=10", {err, busy});
    end
    @(posedge clk); #1;
    checks++;
    if ({err, busy, bus.out_valid} !== 3'b000 || err_cnt !== e0 + 1) begin
      failures++;
      $display("FAIL err_once got=%b/%0d exp=000/%0d", {err, busy, bus.out_valid}, err_cnt - e0, 1);
    end
    checks++;
    if ({bus.rom_address_a, bus.rom_address_b} !== a0) begin
      failures++;
      $display("FAIL err_addr got=%h exp=%h", {bus.rom_address_a, bus.rom_address_b}, a0);
    end
  endtask

  task automatic test_busy_restart;
    int k, cyc, e0;
    k = $urandom_range(4, 9);
    got.delete();
    e0 = err_cnt;
    bus.out_ready = 1'($urandom_range(0, 1));
    start_kernel(k);
    bus.out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1;
    sel = 4'd3;
    @(posedge clk); #1;
    start = 0;
    drain(1, cyc);
    checks++;
    if (got.size() !== NP || done !== 1'b1) begin
      failures++;
      $display("FAIL restart_count got=%0d/%b exp=%0d/1", got.size(), done, NP);
    end
    for (int p = 0; p < NP && p < got.size(); p++) begin
      checks++;
      if (got[p] !== exp_pair(k, p)) begin
        failures++;
        $display("FAIL restart_pair%0d got=%h exp=%h", p, got[p], exp_pair(k, p));
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, bus.out_valid} !== 2'b00 || err_cnt !== e0) begin
      failures++;
      $display("FAIL restart_ignored got=%b/%0d exp=00/0", {busy, bus.out_valid}, err_cnt - e0);
    end
  endtask

  task automatic test_stall20;
    int k, cyc;
    k = $urandom_range(0, 9);
    got.delete();
    stab_viol = 0;
    bus.out_ready = 0;
    start_kernel(k);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (got.size() !== 0 || bus.out_valid !== 1'b1 || cur !== exp_pair(k, 0)) begin
      failures++;
      $display("FAIL stall_head got=%0d/%b/%h exp=0/1/%h", got.size(), bus.out_valid, cur, exp_pair(k, 0));
    end
    checks++;
    if (int'(bus.rom_address_a) > k * KL + 4) begin
      failures++;
      $display("FAIL stall_issue got=%h exp<=%h", bus.rom_address_a, 8'(k * KL + 4));
    end
    drain(0, cyc);
    checks++;
    if (got.size() !== NP || done !== 1'b1 || stab_viol !== 0) begin
      failures++;
      $display("FAIL stall_drain got=%0d/%b/%0d exp=%0d/1/0", got.size(), done, stab_viol, NP);
    end
    for (int p = 0; p < NP && p < got.size(); p++) begin
      checks++;
      if (got[p] !== exp_pair(k, p)) begin
        failures++;
        $display("FAIL stall_pair%0d got=%h exp=%h", p, got[p], exp_pair(k, p));
      end
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    got.delete();
    bus.out_ready = 1;
    start_kernel($urandom_range(0, 9));
    repeat (14) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    checks++;
    if ({busy, done, bus.out_valid, bus.out_w0, bus.out_w1, bus.rom_address_a, bus.rom_address_b} !== 51'h0) begin
      failures++;
      $display("FAIL midreset_clear got=%b%b%b %h %h %h %h exp=all zero", busy, done, bus.out_valid,
               bus.out_w0, bus.out_w1, bus.rom_address_a, bus.rom_address_b);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_nodone got=%b exp=0", done);
    end
    rst_n = 1;
    got.delete();
    start_kernel(1);
    drain(0, cyc);
    checks++;
    if (got.size() < 1 || got[0] !== {16'h1019, 16'h101A, 2'b10}) begin
      failures++;
      $display("FAIL midreset_first got=%h exp=%h", got.size() > 0 ? got[0] : 34'h0, {16'h1019, 16'h101A, 2'b10});
    end
    checks++;
    if (got.size() !== NP || done !== 1'b1) begin
      failures++;
      $display("FAIL midreset_count got=%0d/%b exp=%0d/1", got.size(), done, NP);
    end
    for (int p = 0; p < NP && p < got.size(); p++) begin
      checks++;
      if (got[p] !== exp_pair(1, p)) begin
        failures++;
        $display("FAIL midreset_pair%0d got=%h exp=%h", p, got[p], exp_pair(1, p));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'(32'h1000 + i);
    test_reset();
    test_sel0();
    test_random9();
    test_err();
    test_busy_restart();
    test_stall20();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
